hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core. Owns the IF/ID register's write-enable and flush, the PC write-enable, and the ID/EX bubble insert.
- Resolves three hazard types with fixed priority:
  - control redirect from EX
  - multi-cycle EX operation (mul/div)
  - load-use
- Sits beside the decode stage. Consumes decode/EX fields and produces all stall/flush strobes, plus a sticky timeout flag and performance counters.

Parameters:
- FLUSH_CYCLES, 1, number of consecutive cycles the front end is flushed after a redirect (1..7).
- MD_TIMEOUT, 64, maximum cycles a multi-cycle op may hold EX before the timeout flag sets (≥2).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- id_rs1  input  5  rs1 index of the instruction in ID
- id_rs2  input  5  rs2 index of the instruction in ID
- id_use_rs1  input  1  ID instruction reads rs1
- id_use_rs2  input  1  ID instruction reads rs2
- ex_mem_read  input  1  instruction in EX is a load
- ex_rd  input  5  destination of the EX instruction
- ex_redirect  input  1  branch taken / jump resolved in EX this cycle
- ex_md_busy  input  1  EX holds an unfinished multi-cycle op (level)
- pc_write  output  1  PC register write-enable
- if_id_write  output  1  IF/ID write-enable
- if_id_flush  output  1  IF/ID flush (zeroes pc/instr)
- id_ex_flush  output  1  ID/EX bubble insert
- ex_hold  output  1  freezes ID/EX, EX/MEM advance and the EX unit
- state_o  output  2  current FSM state (00 RUN, 01 FLUSH, 10 MD_WAIT)
- md_timeout  output  1  sticky: multi-cycle op exceeded MD_TIMEOUT
- stall_cnt  output  CNT_W  cycles with pc_write=0 since reset
- flush_cnt  output  CNT_W  redirect events since reset

Behaviour:

Reset
- While reset=1, outputs are forced to:
  - pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, ex_hold=0
  - state_o=RUN, md_timeout=0, counters=0
- Reset asserted mid-FLUSH or mid-MD_WAIT aborts the sequence immediately.
- On the first edge after release, the FSM is in RUN.

Load-use hazard
- lu = ex_mem_read & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).

RUN state (outputs combinational from state and inputs; priority top-down)
1. ex_redirect=1:
   - pc_write=1, if_id_flush=1, id_ex_flush=1, ex_hold=0.
   - Next state is FLUSH if FLUSH_CYCLES>1, else RUN.
   - Load remaining=FLUSH_CYCLES-1. flush_cnt+1.
2. ex_md_busy=1:
   - pc_write=0, if_id_write=0, ex_hold=1, flushes=0.
   - Next state MD_WAIT. md_cnt=1.
3. lu=1:
   - pc_write=0, if_id_write=0, id_ex_flush=1, ex_hold=0. Gives exactly one bubble.
   - Stay in RUN; the load moves to MEM so lu clears next cycle.
4. Otherwise: pc_write=1, if_id_write=1, all flushes/hold 0.

FLUSH state
- pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1.
- Decrement remaining; leave to RUN in the cycle remaining==1.
- ex_redirect in FLUSH: reload remaining=FLUSH_CYCLES-1 and count it.
- ex_md_busy and lu are ignored in FLUSH.

MD_WAIT state
- While ex_md_busy=1: same outputs as RUN case 2; md_cnt saturating increment.
- When md_cnt reaches MD_TIMEOUT, md_timeout sets. It stays set until reset; the stall continues.
- Cycle ex_md_busy=0: outputs evaluated as RUN (including lu and redirect rules), and next state is RUN.
  - ex_redirect together with ex_md_busy=0 in this cycle follows RUN case 1.
  - ex_redirect while ex_md_busy=1 is illegal; it is ignored, and verification asserts it never occurs.

Invariants and counters
- Invariant: if_id_flush=1 implies pc_write=1 outside reset.
- Invariant: ex_hold=1 implies id_ex_flush=0.
- stall_cnt increments every cycle pc_write=0 with reset=0. Counters wrap at 2^CNT_W.
- Latency: all strobes are same-cycle combinational. Only the state, remaining count, md_cnt, timeout flag and counters are registered.

Test Plan:
1. Reset mid-MD_WAIT: busy held 5 cycles, reset pulsed async between edges -> outputs immediately at reset values. After release: state_o=00, stall_cnt=0, md_timeout=0.
2. Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> one cycle with pc_write=0, if_id_write=0, id_ex_flush=1, then normal. ex_rd=0 gives no stall. stall_cnt=1.
3. Redirect with FLUSH_CYCLES=3: ex_redirect one cycle -> if_id_flush=1 for 3 consecutive cycles, state_o 00→01→01→00, flush_cnt=1. A second redirect in cycle 2 extends the flush to cycle 4, flush_cnt=2.
4. Priority: ex_redirect, ex_md_busy and lu all high in RUN -> redirect outputs only, no hold, state→FLUSH/RUN, stall_cnt unchanged.
5. Multi-cycle op: ex_md_busy high 10 cycles with lu also true -> ex_hold=1, pc_write=0 for 10 cycles. Release cycle then shows the lu bubble. stall_cnt=11.
6. Timeout with MD_TIMEOUT=4: busy high 6 cycles -> md_timeout rises in cycle 4, remains 1 after busy drops, clears only on reset.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Purpose: pipeline sequencing controller; resolves redirect, multi-cycle EX and load-use hazards in that priority.
// Latency: every stall/flush strobe is same-cycle combinational; state, flush/md counters, timeout and perf counters are registered.
// Backpressure: pc_write/if_id_write drop to hold the front end; ex_hold freezes EX while a mul/div is unfinished.
module hazard_stall_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MD_TIMEOUT   = 64,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             ex_md_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_hold,
  output logic [1:0]       state_o,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int MD_W = $clog2(MD_TIMEOUT + 1);

  // Flush cycles still owed after the redirect cycle itself.
  localparam logic [2:0]       REM_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [MD_W-1:0]  MD_MAX     = MD_W'(MD_TIMEOUT);
  localparam logic [MD_W-1:0]  MD_ONE     = MD_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_FLUSH   = 2'b01,
    ST_MD_WAIT = 2'b10
  } state_t;

  // A single-cycle flush never needs the FLUSH state.
  localparam state_t REDIRECT_NEXT = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;

  state_t            state_q;
  state_t            state_d;
  logic [2:0]        rem_q;
  logic [2:0]        rem_d;
  logic [MD_W-1:0]   md_cnt_q;
  logic [MD_W-1:0]   md_cnt_d;
  logic              timeout_q;
  logic              timeout_d;
  logic              redirect_evt;
  logic              lu;

  // Load-use: the load in EX writes a register the ID instruction reads (x0 never hazards).
  always_comb begin
    lu = ex_mem_read && (ex_rd != 5'd0) &&
         ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  end

  // Next-state and strobe generation; reset forces the strobes to a safe flush pattern.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    md_cnt_d     = md_cnt_q;
    timeout_d    = timeout_q;
    redirect_evt = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_hold      = 1'b0;

    if (state_q == ST_FLUSH) begin
      // Front end keeps fetching the redirect target while wrong-path work is squashed.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      if (ex_redirect) begin
        rem_d        = REM_RELOAD;
        redirect_evt = 1'b1;
      end else if (rem_q <= 3'd1) begin
        rem_d   = 3'd0;
        state_d = ST_RUN;
      end else begin
        rem_d = rem_q - 3'd1;
      end
    end else if ((state_q == ST_MD_WAIT) && ex_md_busy) begin
      // Op still running: hold everything; a redirect here is illegal and ignored.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      ex_hold     = 1'b1;
      md_cnt_d    = (md_cnt_q == MD_MAX) ? MD_MAX : (md_cnt_q + MD_ONE);
      if (md_cnt_d == MD_MAX) begin
        timeout_d = 1'b1;
      end
    end else begin
      // RUN, or the release cycle of MD_WAIT which behaves exactly like RUN.
      state_d = ST_RUN;
      if (ex_redirect) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        rem_d        = REM_RELOAD;
        state_d      = REDIRECT_NEXT;
        redirect_evt = 1'b1;
      end else if (ex_md_busy) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        ex_hold     = 1'b1;
        md_cnt_d    = MD_ONE;
        state_d     = ST_MD_WAIT;
      end else if (lu) begin
        // One bubble: the load advances to MEM, so the hazard is gone next cycle.
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
    end

    if (reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      ex_hold     = 1'b0;
    end
  end

  // FSM, flush countdown, multi-cycle watchdog and sticky timeout registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RUN;
      rem_q     <= 3'd0;
      md_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      md_cnt_q  <= md_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Performance counters; both wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (redirect_evt) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end

  assign state_o    = state_q;
  assign md_timeout = timeout_q;

  // Structural guarantees the surrounding pipeline relies on.
  a_no_redirect_in_md_busy: assert property (@(posedge clk) disable iff (reset)
    !((state_q == ST_MD_WAIT) && ex_md_busy && ex_redirect));
  a_flush_implies_pc_write: assert property (@(posedge clk) disable iff (reset)
    if_id_flush |-> pc_write);
  a_hold_excludes_bubble: assert property (@(posedge clk) disable iff (reset)
    ex_hold |-> !id_ex_flush);

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Purpose: self-checking bench for hazard_stall_ctrl against a cycle-level reference model.
// Latency: inputs change 1 time unit after a rising edge; outputs are compared 2 units later.
// Backpressure: n/a (bench drives all inputs; redirect is never driven during a busy multi-cycle wait).
module tb_hazard_stall_ctrl;
  localparam int FC   = 3;
  localparam int MT   = 4;
  localparam int CW   = 16;
  localparam int MASK = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [4:0]    id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic          id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic          ex_mem_read = 1'b0, ex_redirect = 1'b0, ex_md_busy = 1'b0;
  logic          pc_write, if_id_write, if_id_flush, id_ex_flush, ex_hold, md_timeout;
  logic [1:0]    state_o;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_stall_ctrl #(.FLUSH_CYCLES(FC), .MD_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect), .ex_md_busy(ex_md_busy),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_hold(ex_hold), .state_o(state_o),
    .md_timeout(md_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
  endtask

  // Reference model: flush cycles still owed, consecutive busy cycles held, event tallies.
  int m_flush_left = 0;
  int m_md_run     = 0;
  int m_stall      = 0;
  int m_flush      = 0;
  bit m_tmo        = 1'b0;
  bit e_pc, e_ifw, e_iff, e_idf, e_hold;

  function automatic bit lu_now();
    return ex_mem_read && (ex_rd != 5'd0) &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  task automatic model_reset();
    m_flush_left = 0; m_md_run = 0; m_stall = 0; m_flush = 0; m_tmo = 1'b0;
  endtask

  // Expected strobes for the current cycle, straight from the hazard priority rules.
  task automatic expect_now();
    {e_pc, e_ifw, e_iff, e_idf, e_hold} = 5'b11000;
    if (reset)                                {e_pc, e_ifw, e_iff, e_idf, e_hold} = 5'b00110;
    else if (m_flush_left > 0)                {e_pc, e_ifw, e_iff, e_idf, e_hold} = 5'b11110;
    else if (m_md_run > 0 && ex_md_busy)      {e_pc, e_ifw, e_iff, e_idf, e_hold} = 5'b00001;
    else if (ex_redirect)                     {e_pc, e_ifw, e_iff, e_idf, e_hold} = 5'b11110;
    else if (ex_md_busy)                      {e_pc, e_ifw, e_iff, e_idf, e_hold} = 5'b00001;
    else if (lu_now())                        {e_pc, e_ifw, e_iff, e_idf, e_hold} = 5'b00010;
  endtask

  task automatic check_outputs();
    int es;
    expect_now();
    es = reset ? 0 : (m_flush_left > 0) ? 1 : (m_md_run > 0) ? 2 : 0;
    chk("pc_write",    32'(pc_write),    32'(e_pc));
    chk("if_id_write", 32'(if_id_write), 32'(e_ifw));
    chk("if_id_flush", 32'(if_id_flush), 32'(e_iff));
    chk("id_ex_flush", 32'(id_ex_flush), 32'(e_idf));
    chk("ex_hold",     32'(ex_hold),     32'(e_hold));
    chk("state_o",     32'(state_o),     32'(es));
    chk("md_timeout",  32'(md_timeout),  32'(m_tmo));
    chk("stall_cnt",   32'(stall_cnt),   32'(m_stall & MASK));
    chk("flush_cnt",   32'(flush_cnt),   32'(m_flush & MASK));
  endtask

  // Advance the model across one rising edge using this cycle's inputs.
  task automatic model_edge();
    bit md_hold;
    if (reset) begin
      model_reset();
      return;
    end
    if (!e_pc) m_stall++;
    md_hold = (m_md_run > 0) && ex_md_busy;
    if (ex_redirect && !md_hold) begin
      m_flush++;
      m_flush_left = FC - 1;
      m_md_run = 0;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (ex_md_busy) begin
      if (m_md_run < MT) m_md_run++;
      if (m_md_run == MT) m_tmo = 1'b1;
    end else begin
      m_md_run = 0;
    end
  endtask

  // One cycle: settle, compare, take the edge, step the model.
  task automatic tick();
    #2;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Reset asserted between edges: outputs must react without waiting for the clock.
  task automatic async_reset_pulse();
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic clear_inputs();
    {id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, ex_md_busy} = '0;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    tick();
    tick();
    reset = 1'b0;

    // Reset in the middle of a multi-cycle wait.
    ex_md_busy = 1'b1;
    repeat (5) tick();
    chk("t1_in_md_wait", 32'(state_o), 32'd2);
    async_reset_pulse();
    ex_md_busy = 1'b0;
    chk("t1_state_after", 32'(state_o), 32'd0);
    chk("t1_stall_after", 32'(stall_cnt), 32'd0);
    chk("t1_tmo_after", 32'(md_timeout), 32'd0);
    tick();

    // Load-use: exactly one bubble, then x0 as destination never stalls.
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    #1;
    chk("t2_bubble_pc", 32'(pc_write), 32'd0);
    chk("t2_bubble_idex", 32'(id_ex_flush), 32'd1);
    tick();
    ex_mem_read = 1'b0;
    tick();
    chk("t2_stall_cnt", 32'(stall_cnt), 32'd1);
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
    #1;
    chk("t2_rd0_no_stall", 32'(pc_write), 32'd1);
    tick();
    clear_inputs();

    // Redirect: three flushed cycles, then a redirect in cycle 2 stretches it to cycle 4.
    ex_redirect = 1'b1;
    tick();
    ex_redirect = 1'b0;
    chk("t3_c2_state", 32'(state_o), 32'd1);
    tick();
    chk("t3_c3_state", 32'(state_o), 32'd1);
    chk("t3_c3_flush", 32'(if_id_flush), 32'd1);
    tick();
    chk("t3_c4_state", 32'(state_o), 32'd0);
    chk("t3_c4_flush", 32'(if_id_flush), 32'd0);
    chk("t3_flush_cnt", 32'(flush_cnt), 32'd1);
    ex_redirect = 1'b1;
    tick();
    tick();
    ex_redirect = 1'b0;
    tick();
    chk("t3_ext_c4_flush", 32'(if_id_flush), 32'd1);
    tick();
    chk("t3_ext_c5_flush", 32'(if_id_flush), 32'd0);
    chk("t3_ext_flush_cnt", 32'(flush_cnt), 32'd3);
    tick();

    // Priority: redirect beats busy and load-use.
    ex_redirect = 1'b1; ex_md_busy = 1'b1;
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
    #1;
    chk("t4_hold", 32'(ex_hold), 32'd0);
    chk("t4_pc", 32'(pc_write), 32'd1);
    tick();
    chk("t4_state", 32'(state_o), 32'd1);
    chk("t4_stall_same", 32'(stall_cnt), 32'd1);
    ex_redirect = 1'b0; ex_md_busy = 1'b0;
    tick();
    tick();

    // Multi-cycle op with load-use pending: 10 held cycles, then the bubble.
    ex_md_busy = 1'b1;
    repeat (10) tick();
    ex_md_busy = 1'b0;
    #1;
    chk("t5_release_bubble", 32'(id_ex_flush), 32'd1);
    chk("t5_release_hold", 32'(ex_hold), 32'd0);
    tick();
    clear_inputs();
    chk("t5_stall_cnt", 32'(stall_cnt), 32'd12);
    tick();

    // Timeout with MD_TIMEOUT=4: sticky from the 4th busy cycle until reset.
    async_reset_pulse();
    ex_md_busy = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("t6_tmo", 32'(md_timeout), (k >= MT) ? 32'd1 : 32'd0);
    end
    ex_md_busy = 1'b0;
    tick();
    tick();
    chk("t6_tmo_sticky", 32'(md_timeout), 32'd1);
    async_reset_pulse();
    chk("t6_tmo_cleared", 32'(md_timeout), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) ex_md_busy = ~ex_md_busy;
      ex_mem_read = ($urandom_range(0, 2) == 0);
      ex_rd       = 5'($urandom_range(0, 3));
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_use_rs1  = $urandom_range(0, 1) == 1;
      id_use_rs2  = $urandom_range(0, 1) == 1;
      ex_redirect = ($urandom_range(0, 9) == 0) && !(m_md_run > 0 && ex_md_busy);
      if ($urandom_range(0, 299) == 0) async_reset_pulse();
      else tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Bound the run so a stuck bench cannot hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
